// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RMII receive packer.
package eth_rx_pkg;

  localparam int unsigned C_FRAME_LEN_WIDTH = 16;
  localparam logic [1:0]  C_PREAMBLE_DIBIT  = 2'b01;
  localparam logic [1:0]  C_SFD_DIBIT       = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    FLUSH,
    TRAILER,
    DROP
  } rx_state_t;

  // Self-delimiting length word appended after a frame's payload.
  function automatic logic [31:0] trailer_word(input logic                         err,
                                               input logic [C_FRAME_LEN_WIDTH-1:0] len);
    return {err, 15'b0, len};
  endfunction

endpackage

// File: rtl/rmii_dibit_to_byte.sv
// Assembles RMII dibits (LSB first) into bytes; the completed byte is
// presented combinationally alongside its final dibit.
module rmii_dibit_to_byte (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] dibit,
  output logic [7:0] rx_byte_c,
  output logic       byte_valid_c,
  output logic [1:0] phase
);

  logic [5:0] shift_q, shift_d;
  logic [1:0] phase_q, phase_d;

  always_comb begin
    shift_d = shift_q;
    phase_d = phase_q;
    if (clr) begin
      shift_d = '0;
      phase_d = '0;
    end else if (en) begin
      shift_d = {dibit, shift_q[5:2]};
      phase_d = phase_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      phase_q <= '0;
    end else begin
      shift_q <= shift_d;
      phase_q <= phase_d;
    end
  end

  assign rx_byte_c    = {dibit, shift_q};
  assign byte_valid_c = en && !clr && (phase_q == 2'd3);
  assign phase        = phase_q;

endmodule

// File: rtl/eth_rmii_rx_packer.sv
// RMII receive front end: strips preamble/SFD and packs payload bytes into
// little-endian words. Define ETH_RX_LEN_TRAILER_EN to append a length word.
module eth_rmii_rx_packer
  import eth_rx_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH   = 32,
  parameter int unsigned C_MAX_BYTES    = 1522,
  parameter int unsigned C_MIN_PREAMBLE = 8
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_aresetn,
  input  logic                         rmii_crs_dv,
  input  logic [1:0]                   rmii_rxd,
  input  logic                         rmii_rx_er,
  output logic [C_DATA_WIDTH-1:0]      eth_rx_data,
  output logic                         eth_wr_en,
  output logic                         frame_done,
  output logic                         frame_err,
  output logic [C_FRAME_LEN_WIDTH-1:0] frame_len
);

  localparam int unsigned LANES = C_DATA_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(LANES);
  localparam int unsigned PRE_W = $clog2(C_MIN_PREAMBLE + 1);
  localparam int unsigned LEN_W = C_FRAME_LEN_WIDTH;

  logic                    crs_dv_q, rx_er_q;
  logic [1:0]              rxd_q;
  rx_state_t               state_q, state_d;
  logic [PRE_W-1:0]        pre_cnt_q, pre_cnt_d;
  logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
  logic [C_DATA_WIDTH-1:0] word_q, word_d, data_q, data_d;
  logic [LEN_W-1:0]        len_q, len_d, flen_q, flen_d;
  logic                    err_q, err_d, ovf_q, ovf_d, pend_q, pend_d;
  logic                    wr_q, wr_d, done_q, done_d, ferr_q, ferr_d;
  logic                    close_c, d2b_en_c, d2b_clr_c;
  logic [7:0]              rx_byte_c;
  logic                    byte_valid_c;
  logic [1:0]              phase;

  assign d2b_en_c  = (state_q == PAYLOAD) && crs_dv_q;
  assign d2b_clr_c = (state_q != PAYLOAD);

  rmii_dibit_to_byte u_dibit_to_byte (
    .clk          (s_axi_aclk),
    .rst_n        (s_axi_aresetn),
    .en           (d2b_en_c),
    .clr          (d2b_clr_c),
    .dibit        (rxd_q),
    .rx_byte_c    (rx_byte_c),
    .byte_valid_c (byte_valid_c),
    .phase        (phase)
  );

  // Frame FSM, word packer and length/error bookkeeping.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    len_d      = len_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    pend_d     = 1'b0;
    data_d     = data_q;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    flen_d     = flen_q;
    close_c    = 1'b0;

    // Deferred done keeps the pulse one cycle behind the final write.
    if (pend_q) begin
      done_d = 1'b1;
      ferr_d = err_q;
      flen_d = len_q;
    end

    case (state_q)
      IDLE: begin
        if (crs_dv_q && rxd_q == C_PREAMBLE_DIBIT) begin
          pre_cnt_d = PRE_W'(1);
          state_d   = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (!crs_dv_q) begin
          state_d = IDLE;
        end else if (rxd_q == C_PREAMBLE_DIBIT) begin
          if (pre_cnt_q != PRE_W'(C_MIN_PREAMBLE)) pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end else if (rxd_q == C_SFD_DIBIT && pre_cnt_q >= PRE_W'(C_MIN_PREAMBLE - 1)) begin
          state_d    = PAYLOAD;
          byte_idx_d = '0;
          word_d     = '0;
          len_d      = '0;
          err_d      = 1'b0;
          ovf_d      = 1'b0;
        end else begin
          state_d = DROP;
        end
      end
      PAYLOAD: begin
        if (rx_er_q) err_d = 1'b1;
        if (!crs_dv_q) begin
          if (phase != 2'd0) err_d = 1'b1;
          if (byte_idx_q != '0) state_d = FLUSH;
          else                  close_c = 1'b1;
        end else if (byte_valid_c) begin
          if (len_q == LEN_W'(C_MAX_BYTES)) begin
            err_d = 1'b1;
            ovf_d = 1'b1;
            if (byte_idx_q != '0) state_d = FLUSH;
            else                  close_c = 1'b1;
          end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
              if (byte_idx_q == IDX_W'(i)) word_d[i*8 +: 8] = rx_byte_c;
            end
            len_d = len_q + LEN_W'(1);
            if (byte_idx_q == IDX_W'(LANES - 1)) begin
              data_d     = word_d;
              wr_d       = 1'b1;
              word_d     = '0;
              byte_idx_d = '0;
            end else begin
              byte_idx_d = byte_idx_q + IDX_W'(1);
            end
          end
        end
      end
      FLUSH: begin
        data_d     = word_q;
        wr_d       = 1'b1;
        word_d     = '0;
        byte_idx_d = '0;
`ifdef ETH_RX_LEN_TRAILER_EN
        state_d    = TRAILER;
`else
        pend_d     = 1'b1;
        state_d    = ovf_q ? DROP : IDLE;
`endif
      end
      TRAILER: begin
        data_d  = C_DATA_WIDTH'(trailer_word(err_q, len_q));
        wr_d    = 1'b1;
        pend_d  = 1'b1;
        state_d = ovf_q ? DROP : IDLE;
      end
      DROP: begin
        if (!crs_dv_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Frame ended on a word boundary: nothing left to flush.
    if (close_c) begin
`ifdef ETH_RX_LEN_TRAILER_EN
      state_d = TRAILER;
`else
      done_d  = 1'b1;
      ferr_d  = err_d;
      flen_d  = len_d;
      state_d = ovf_d ? DROP : IDLE;
`endif
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      crs_dv_q   <= 1'b0;
      rxd_q      <= '0;
      rx_er_q    <= 1'b0;
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      flen_q     <= '0;
    end else begin
      crs_dv_q   <= rmii_crs_dv;
      rxd_q      <= rmii_rxd;
      rx_er_q    <= rmii_rx_er;
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      len_q      <= len_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      flen_q     <= flen_d;
    end
  end

  assign eth_rx_data = data_q;
  assign eth_wr_en   = wr_q;
  assign frame_done  = done_q;
  assign frame_err   = ferr_q;
  assign frame_len   = flen_q;

endmodule

// File: tb/tb_eth_rmii_rx_packer.sv
// Directed scoreboard bench for eth_rmii_rx_packer (default parameters).
module tb_eth_rmii_rx_packer;

  localparam int unsigned DW   = 32;
  localparam int unsigned MAXB = 1522;
  localparam int unsigned MINP = 8;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          crs_dv = 1'b0;
  logic [1:0]    rxd    = 2'b00;
  logic          rx_er  = 1'b0;
  logic [DW-1:0] eth_rx_data;
  logic          eth_wr_en;
  logic          frame_done;
  logic          frame_err;
  logic [15:0]   frame_len;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [31:0]   exp_wr[$];
  logic [16:0]   exp_done[$];
  logic [7:0]    pl[$];
  logic [16:0]   dexp;

  eth_rmii_rx_packer #(
    .C_DATA_WIDTH   (DW),
    .C_MAX_BYTES    (MAXB),
    .C_MIN_PREAMBLE (MINP)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .rmii_crs_dv   (crs_dv),
    .rmii_rxd      (rxd),
    .rmii_rx_er    (rx_er),
    .eth_rx_data   (eth_rx_data),
    .eth_wr_en     (eth_wr_en),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .frame_len     (frame_len)
  );

  always #10 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [1:0] d, input logic er);
    crs_dv = dv;
    rxd    = d;
    rx_er  = er;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00, 1'b0);
  endtask

  task automatic preamble(input int n);
    repeat (n) drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b11, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic er);
    for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2], er);
  endtask

  // Reference model: words, optional trailer and done record for pl[].
  task automatic expect_frame(input int er_at, input int n_extra);
    int          n;
    logic        err;
    logic [31:0] w;
    n   = (pl.size() > int'(MAXB)) ? int'(MAXB) : pl.size();
    err = (pl.size() > int'(MAXB)) || (er_at >= 0 && er_at < n) || (n_extra != 0);
    for (int i = 0; i < n; i += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++) if (i + j < n) w[8*j +: 8] = pl[i+j];
      exp_wr.push_back(w);
    end
`ifdef ETH_RX_LEN_TRAILER_EN
    exp_wr.push_back({err, 15'b0, 16'(n)});
`endif
    exp_done.push_back({err, 16'(n)});
  endtask

  task automatic drive_payload(input int er_at, input int n_extra);
    for (int i = 0; i < pl.size(); i++) send_byte(pl[i], i == er_at);
    for (int k = 0; k < n_extra; k++) drive(1'b1, 2'b10, 1'b0);
  endtask

  task automatic send_frame(input int er_at, input int n_extra, input int gap);
    expect_frame(er_at, n_extra);
    preamble(MINP);
    drive_payload(er_at, n_extra);
    idle(gap);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, eth_rx_data, 32'h0);
    check({tag, "_wr_en"}, 32'(eth_wr_en), 32'h0);
    check({tag, "_done"}, 32'(frame_done), 32'h0);
    check({tag, "_err"}, 32'(frame_err), 32'h0);
    check({tag, "_len"}, 32'(frame_len), 32'h0);
  endtask

  // Scoreboard: every write and done pulse is matched against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eth_wr_en) begin
        check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) check("wr_data", eth_rx_data, exp_wr.pop_front());
      end
      if (frame_done) begin
        check("done_excl_wr", 32'(eth_wr_en), 32'd0);
        check("done_after_writes", 32'(exp_wr.size()), 32'd0);
        check("done_expected", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) begin
          dexp = exp_done.pop_front();
          check("frame_err", 32'(frame_err), 32'(dexp[16]));
          check("frame_len", 32'(frame_len), 32'(dexp[15:0]));
        end
      end
    end
  end

  initial begin
    logic [7:0] b5;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // 1: eight bytes, two full words, latency probe on the first word
    pl.delete();
    for (int i = 1; i <= 8; i++) pl.push_back(8'(i));
    expect_frame(-1, 0);
    preamble(MINP);
    for (int i = 0; i < 4; i++) send_byte(pl[i], 1'b0);
    check("latency_cycle1", 32'(eth_wr_en), 32'd0);
    b5 = pl[4];
    drive(1'b1, b5[1:0], 1'b0);
    check("latency_cycle2", 32'(eth_wr_en), 32'd1);
    check("latency_data", eth_rx_data, 32'h04030201);
    drive(1'b1, b5[3:2], 1'b0);
    drive(1'b1, b5[5:4], 1'b0);
    drive(1'b1, b5[7:6], 1'b0);
    for (int i = 5; i < 8; i++) send_byte(pl[i], 1'b0);
    idle(6);

    // 2: five bytes, partial-word flush
    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_frame(-1, 0, 6);

    // 3: 64 bytes with rx_er during byte 20
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i * 3 + 1));
    send_frame(20, 0, 6);

    // alignment error: two stray dibits after three bytes
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(-1, 2, 6);

    // 4: short preamble is dropped, valid frame after one idle cycle
    pl = '{8'h55, 8'h66, 8'h77, 8'h88};
    preamble(4);
    drive_payload(-1, 0);
    idle(1);
    pl.delete();
    for (int i = 0; i < 7; i++) pl.push_back(8'(8'h30 + i));
    send_frame(-1, 0, 6);

    // 5: oversize frame truncated at C_MAX_BYTES
    pl.delete();
    for (int i = 0; i < 1600; i++) pl.push_back(8'(i));
    send_frame(-1, 0, 6);

    // 6: reset after three payload bytes, then a clean 4-byte frame
    pl = '{8'hA1, 8'hA2, 8'hA3};
    preamble(MINP);
    drive_payload(-1, 0);
    rst_n  = 1'b0;
    crs_dv = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(-1, 0, 6);

    for (int i = 0; i < 200 && (exp_wr.size() != 0 || exp_done.size() != 0); i++)
      @(negedge clk);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
